// File: rtl/game_state_controller.sv
// game_state_controller: pinball frame supervisor turning pixel overlaps into per-frame collision pulses, and owning the game state, score, lives and pause; define GAME_CTRL_BONUS_LIFE_EN to award one bonus life per game at BONUS_SCORE
module game_state_controller #(
  parameter int NUM_OBJECTS = 4,
  parameter int LIVES = 3,
  parameter int SCORE_W = 16,
  parameter int POINTS = 10,
  parameter int LOST_DELAY_FRAMES = 60,
  parameter int BONUS_SCORE = 500
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   start_key,
  input  logic                   draw_smiley,
  input  logic                   draw_boarders,
  input  logic                   draw_bottom_boarder,
  input  logic                   draw_flipper,
  input  logic [NUM_OBJECTS-1:0] draw_objects,
  output logic                   collisionSmileyBorders,
  output logic                   collisionSmileyFlipper,
  output logic [NUM_OBJECTS-1:0] hit_objects,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             lives,
  output logic                   pause,
  output logic                   game_over
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, LOST = 2'd2, GAME_OVER = 2'd3;
  localparam int SW = SCORE_W + 32;
  localparam logic [SW-1:0] SCORE_MAX = {{32{1'b0}}, {SCORE_W{1'b1}}};
  logic [1:0] state, state_n;
  logic key_q, start_edge, restart, bonus;
  logic [7:0] lost_cnt, lost_cnt_n;
  logic border_f, flipper_f, bottom_f;
  logic [NUM_OBJECTS-1:0] obj_f;
  logic [4:0] hit_n;
  logic [SW-1:0] sum, score_sat;
  logic [SCORE_W-1:0] score_n;
  logic [2:0] lives_b, lives_n;
  assign restart = start_edge && (state == IDLE || state == GAME_OVER);
  assign sum = SW'(score) + SW'(POINTS) * SW'(hit_n);
  assign score_sat = sum > SCORE_MAX ? SCORE_MAX : sum;
  assign lives_b = bonus ? (lives == 3'd7 ? 3'd7 : lives + 3'd1) : lives;
`ifdef GAME_CTRL_BONUS_LIFE_EN
  logic bonus_armed;
  assign bonus = bonus_armed && SW'(score) < SW'(BONUS_SCORE) && score_sat >= SW'(BONUS_SCORE);
  // one bonus per game: disarm on award, rearm on every restart
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) bonus_armed <= 1'b1;
    else if (restart) bonus_armed <= 1'b1;
    else if (startOfFrame && state == PLAY && bonus) bonus_armed <= 1'b0;
`else
  logic unused_bonus;
  assign bonus = 1'b0;
  assign unused_bonus = ^BONUS_SCORE;
`endif
  // number of obstacles hit during the closing frame
  always_comb begin
    hit_n = '0;
    for (int i = 0; i < NUM_OBJECTS; i++) hit_n = hit_n + 5'(obj_f[i]);
  end
  // game progression: restart beats the frame edge; frame edges score, lose balls and count down LOST
  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    lost_cnt_n = lost_cnt;
    if (restart) begin
      state_n = PLAY;
      score_n = '0;
      lives_n = 3'(LIVES);
    end else if (startOfFrame && state == PLAY) begin
      score_n = score_sat[SCORE_W-1:0];
      lives_n = lives_b - {2'b00, bottom_f};
      state_n = !bottom_f ? PLAY : lives_n == 3'd0 ? GAME_OVER : LOST;
      lost_cnt_n = 8'(LOST_DELAY_FRAMES);
    end else if (startOfFrame && state == LOST) begin
      lost_cnt_n = lost_cnt - 8'd1;
      state_n = lost_cnt == 8'd1 ? PLAY : LOST;
    end
  end
  // start key rising-edge detector; key assumed held across reset is not a press
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      key_q <= 1'b1;
      start_edge <= 1'b0;
    end else begin
      key_q <= start_key;
      start_edge <= start_key & ~key_q;
    end
  // sticky overlap flags collected over one frame of play
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      border_f <= 1'b0;
      flipper_f <= 1'b0;
      bottom_f <= 1'b0;
      obj_f <= '0;
    end else if (startOfFrame || restart) begin
      border_f <= 1'b0;
      flipper_f <= 1'b0;
      bottom_f <= 1'b0;
      obj_f <= '0;
    end else if (state == PLAY && draw_smiley) begin
      border_f <= border_f | draw_boarders;
      flipper_f <= flipper_f | draw_flipper;
      bottom_f <= bottom_f | draw_bottom_boarder;
      obj_f <= obj_f | draw_objects;
    end
  // one-cycle collision pulses at the frame edge; a restart discards the frame
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      collisionSmileyBorders <= 1'b0;
      collisionSmileyFlipper <= 1'b0;
      hit_objects <= '0;
    end else begin
      collisionSmileyBorders <= startOfFrame && !restart && border_f;
      collisionSmileyFlipper <= startOfFrame && !restart && flipper_f;
      hit_objects <= startOfFrame && !restart ? obj_f : '0;
    end
  // registered state, score, lives and status outputs
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      score <= '0;
      lives <= 3'(LIVES);
      lost_cnt <= '0;
      pause <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      score <= score_n;
      lives <= lives_n;
      lost_cnt <= lost_cnt_n;
      pause <= state_n != PLAY;
      game_over <= state_n == GAME_OVER;
    end
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed stimulus, per-cycle model comparison of two configurations plus literal checkpoints
module tb_game_state_controller;
  logic clk, resetN, sof, key, smiley, brd, bot, flip;
  logic [3:0] objs;
  logic border_a, flip_a, pause_a, go_a, border_b, flip_b, pause_b, go_b;
  logic [3:0] hit_a, hit_b;
  logic [15:0] score_a;
  logic [7:0] score_b;
  logic [2:0] lives_a, lives_b;
  int vectors = 0, miscompares = 0;
  game_state_controller dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(key), .draw_smiley(smiley),
    .draw_boarders(brd), .draw_bottom_boarder(bot), .draw_flipper(flip), .draw_objects(objs),
    .collisionSmileyBorders(border_a), .collisionSmileyFlipper(flip_a), .hit_objects(hit_a),
    .score(score_a), .lives(lives_a), .pause(pause_a), .game_over(go_a));
  game_state_controller #(.SCORE_W(8), .BONUS_SCORE(20)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(key), .draw_smiley(smiley),
    .draw_boarders(brd), .draw_bottom_boarder(bot), .draw_flipper(flip), .draw_objects(objs),
    .collisionSmileyBorders(border_b), .collisionSmileyFlipper(flip_b), .hit_objects(hit_b),
    .score(score_b), .lives(lives_b), .pause(pause_b), .game_over(go_b));
  initial clk = 0;
  always #5 clk = ~clk;
  // model: mode 0 idle, 1 play, 2 lost, 3 game over
  int md[2], sc[2], lv[2], cd[2];
  int smax[2] = '{65535, 255};
  bit fb[2], ff[2], fbot[2], eb[2], ef[2];
  bit [3:0] fo[2], eh[2];
  bit pend, kprev;
`ifdef GAME_CTRL_BONUS_LIFE_EN
  int thr[2] = '{500, 20};
  bit armed[2];
`endif
  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      md[k] = 0; sc[k] = 0; lv[k] = 3; cd[k] = 0;
      fb[k] = 0; ff[k] = 0; fbot[k] = 0; fo[k] = 0; eb[k] = 0; ef[k] = 0; eh[k] = 0;
`ifdef GAME_CTRL_BONUS_LIFE_EN
      armed[k] = 1;
`endif
    end
    pend = 0; kprev = 1;
  endtask
  task automatic mstep(input int k);
    int nw;
    eb[k] = 0; ef[k] = 0; eh[k] = 0;
    if (pend && (md[k] == 0 || md[k] == 3)) begin
      md[k] = 1; sc[k] = 0; lv[k] = 3;
      fb[k] = 0; ff[k] = 0; fbot[k] = 0; fo[k] = 0;
`ifdef GAME_CTRL_BONUS_LIFE_EN
      armed[k] = 1;
`endif
    end else if (sof) begin
      eb[k] = fb[k]; ef[k] = ff[k]; eh[k] = fo[k];
      if (md[k] == 1) begin
        nw = sc[k] + 10 * $countones(fo[k]);
        if (nw > smax[k]) nw = smax[k];
`ifdef GAME_CTRL_BONUS_LIFE_EN
        if (armed[k] && sc[k] < thr[k] && nw >= thr[k]) begin
          armed[k] = 0;
          if (lv[k] < 7) lv[k]++;
        end
`endif
        sc[k] = nw;
        if (fbot[k]) begin
          lv[k]--;
          md[k] = lv[k] == 0 ? 3 : 2;
          cd[k] = 60;
        end
      end else if (md[k] == 2) begin
        cd[k]--;
        if (cd[k] == 0) md[k] = 1;
      end
      fb[k] = 0; ff[k] = 0; fbot[k] = 0; fo[k] = 0;
    end else if (md[k] == 1 && smiley) begin
      fb[k] |= brd; ff[k] |= flip; fbot[k] |= bot; fo[k] |= objs;
    end
  endtask
  task automatic cmp(input int k, input logic b, f, input logic [3:0] h, input logic [31:0] s,
                     input logic [2:0] l, input logic p, g);
    vectors++;
    if (b !== eb[k] || f !== ef[k] || h !== eh[k] || s !== sc[k] || l !== 3'(lv[k]) ||
        p !== (md[k] != 1) || g !== (md[k] == 3)) begin
      miscompares++;
      $display("FAIL model inst%0d @%0t: got b=%0b f=%0b h=%b s=%0d l=%0d p=%0b g=%0b, expected b=%0b f=%0b h=%b s=%0d l=%0d p=%0b g=%0b",
               k, $time, b, f, h, s, l, p, g, eb[k], ef[k], eh[k], sc[k], lv[k], md[k] != 1, md[k] == 3);
    end
  endtask
  always @(posedge clk or negedge resetN) begin
    if (!resetN) mreset();
    else begin
      mstep(0);
      mstep(1);
      pend = key && !kprev;
      kprev = key;
      #1;
      cmp(0, border_a, flip_a, hit_a, 32'(score_a), lives_a, pause_a, go_a);
      cmp(1, border_b, flip_b, hit_b, 32'(score_b), lives_b, pause_b, go_b);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic frame(input logic [3:0] o, input logic fl, bd, bt, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sof = 0; smiley = 1; objs = o; flip = fl; brd = bd; bot = bt;
    end
    @(negedge clk);
    sof = 0; smiley = 0; objs = 0; flip = 0; brd = 0; bot = 0;
    @(negedge clk);
    sof = 1; smiley = 1; objs = 4'hf; flip = 1; brd = 1; bot = 1;
    @(negedge clk);
    sof = 0; smiley = 0; objs = 0; flip = 0; brd = 0; bot = 0;
  endtask
  task automatic press();
    @(negedge clk) key = 1;
    @(negedge clk);
    @(negedge clk) key = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    resetN = 0; key = 0; sof = 0; smiley = 0; brd = 0; bot = 0; flip = 0; objs = 0;
    repeat (3) @(negedge clk);
    resetN = 1;
    @(negedge clk);
    chk("rst_pause", pause_a, 1);
    chk("rst_score", score_a, 0);
    chk("rst_lives", lives_a, 3);
    chk("rst_game_over", go_a, 0);
    repeat (3) begin
      frame(4'hf, 1, 1, 1, 4);
      chk("idle_hits", hit_a, 0);
      chk("idle_flip", flip_a, 0);
    end
    chk("idle_pause", pause_a, 1);
    press();
    chk("start_pause", pause_a, 0);
    frame(4'b0100, 0, 0, 0, 40);
    chk("obj2_hits", hit_a, 4'b0100);
    chk("obj2_score", score_a, 10);
    @(negedge clk);
    chk("obj2_one_cycle", hit_a, 0);
    frame(4'b1001, 1, 0, 0, 7);
    chk("obj03_hits", hit_a, 4'b1001);
    chk("obj03_flip", flip_a, 1);
    chk("obj03_score", score_a, 30);
`ifdef GAME_CTRL_BONUS_LIFE_EN
    chk("bonus_lives_b", lives_b, 4);
`endif
    frame(4'b0000, 0, 1, 0, 3);
    chk("border_pulse", border_a, 1);
    chk("border_no_flip", flip_a, 0);
    press();
    chk("start_in_play_ignored", score_a, 30);
    repeat (5) frame(4'hf, 0, 0, 0, 2);
    frame(4'b0011, 0, 0, 0, 2);
    chk("b_score_250", score_b, 250);
    frame(4'b0001, 0, 0, 0, 2);
    chk("b_saturate", score_b, 255);
    chk("a_score_260", score_a, 260);
    frame(4'b0001, 0, 0, 0, 2);
    chk("b_stays_255", score_b, 255);
    chk("a_score_270", score_a, 270);
`ifdef GAME_CTRL_BONUS_LIFE_EN
    chk("bonus_only_once_b", lives_b, 4);
`endif
    frame(4'b0010, 0, 0, 1, 3);
    chk("loss1_lives", lives_a, 2);
    chk("loss1_pause", pause_a, 1);
    chk("loss1_hits", hit_a, 4'b0010);
    chk("loss1_score", score_a, 280);
    repeat (59) frame(4'hf, 1, 1, 1, 2);
    chk("lost_59_pause", pause_a, 1);
    chk("lost_no_hits", hit_a, 0);
    frame(4'hf, 1, 1, 1, 2);
    chk("lost_60_play", pause_a, 0);
    chk("lost_end_no_flip", flip_a, 0);
    frame(4'b0000, 0, 0, 1, 2);
    chk("loss2_lives", lives_a, 1);
    repeat (60) frame(4'b0000, 0, 0, 0, 0);
    chk("loss2_back_play", pause_a, 0);
    frame(4'b0000, 0, 0, 1, 2);
    chk("over_flag", go_a, 1);
    chk("over_lives", lives_a, 0);
    chk("over_pause", pause_a, 1);
    @(negedge clk) key = 1;
    @(negedge clk);
    sof = 1; smiley = 1; objs = 4'hf; flip = 1; brd = 1; bot = 1;
    @(negedge clk);
    sof = 0; key = 0; smiley = 0; objs = 0; flip = 0; brd = 0; bot = 0;
    chk("restart_pause", pause_a, 0);
    chk("restart_game_over", go_a, 0);
    chk("restart_score", score_a, 0);
    chk("restart_lives", lives_a, 3);
    chk("restart_no_hits", hit_a, 0);
    frame(4'b0100, 0, 0, 1, 5);
    chk("pre_reset_score", score_a, 10);
    chk("pre_reset_lives", lives_a, 2);
    @(negedge clk) resetN = 0;
    #1;
    chk("async_rst_score", score_a, 0);
    chk("async_rst_lives", lives_a, 3);
    chk("async_rst_pause", pause_a, 1);
    @(negedge clk) resetN = 1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
